// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Memory-side responder for the CPU data port. Holds DEPTH bytes of
//   byte-addressed, big-endian word storage. Accepts one word load/store
//   per req/ready handshake, then inserts WAIT_CYCLES wait states before a
//   single-cycle ack. Misaligned or out-of-range requests complete with err=1
//   and touch neither memory nor rdata.
//
// Ports
//   clk    in   clock, all state updates on the rising edge
//   reset  in   synchronous active-high reset (memory contents are kept)
//   req    in   request valid, sampled only while ready=1
//   we     in   1 = store word, 0 = load word
//   addr   in   32-bit byte address of the word
//   wdata  in   32-bit store data
//   ready  out  idle and able to accept a request
//   ack    out  one-cycle completion pulse
//   rdata  out  load result, valid with ack and held until the next load
//   err    out  request rejected, qualified by ack
//   busy   out  request in flight (~ready)
module data_mem_responder #(
   parameter int unsigned DEPTH       = 256,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        ready,
   output logic        ack,
   output logic [31:0] rdata,
   output logic        err,
   output logic        busy
);

   localparam int unsigned AW        = (DEPTH > 4) ? $clog2(DEPTH) : 2;
   localparam logic [31:0] LAST_WORD = 32'(DEPTH - 4);

   typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;

   logic [7:0]  mem [DEPTH];

   // Request being serviced: live inputs while idle (so a zero-wait instance
   // can commit on the accepting edge), latched copies afterwards.
   logic        cmd_we;
   logic [31:0] cmd_addr;
   logic [31:0] cmd_wdata;
   logic        cmd_err;
   logic [AW-1:0] base;
   logic        commit;
   logic        mem_we;

   always_comb begin
      if (state_q == StIdle) begin
         cmd_we    = we;
         cmd_addr  = addr;
         cmd_wdata = wdata;
      end else begin
         cmd_we    = we_q;
         cmd_addr  = addr_q;
         cmd_wdata = wdata_q;
      end
      cmd_err = (cmd_addr[1:0] != 2'b00) || (cmd_addr > LAST_WORD);
      base    = cmd_addr[AW-1:0];
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         cnt_q   <= 4'd0;
         we_q    <= 1'b0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Storage is never cleared; a reset edge suppresses a pending commit.
   always_ff @(posedge clk) begin
      if (mem_we && !reset) begin
         mem[base]         <= cmd_wdata[31:24];
         mem[base + AW'(1)] <= cmd_wdata[23:16];
         mem[base + AW'(2)] <= cmd_wdata[15:8];
         mem[base + AW'(3)] <= cmd_wdata[7:0];
      end
   end

   // Next-state and commit logic
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      commit  = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (req) begin
               we_d    = we;
               addr_d  = addr;
               wdata_d = wdata;
               if (WAIT_CYCLES == 0) begin
                  state_d = StResp;
                  commit  = 1'b1;
               end else begin
                  state_d = StWait;
                  cnt_d   = 4'(WAIT_CYCLES - 1);
               end
            end
         end
         StWait: begin
            if (cnt_q == 4'd0) begin
               state_d = StResp;
               commit  = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase

      err_d   = err_q;
      rdata_d = rdata_q;
      mem_we  = 1'b0;
      if (commit) begin
         err_d = cmd_err;
         if (!cmd_err) begin
            if (cmd_we) begin
               mem_we = 1'b1;
            end else begin
               rdata_d = {mem[base], mem[base + AW'(1)], mem[base + AW'(2)],
                          mem[base + AW'(3)]};
            end
         end
      end
   end

   // Outputs
   always_comb begin
      ready = (state_q == StIdle);
      ack   = (state_q == StResp);
      busy  = (state_q != StIdle);
      rdata = rdata_q;
      err   = err_q;
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: a WAIT_CYCLES=2 instance for the
// main sequence and a WAIT_CYCLES=0 instance for zero-wait timing.
module tb_data_mem_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic        req, we;
   logic [31:0] addr, wdata, rdata;
   logic        ready, ack, err, busy;
   logic        req0, we0;
   logic [31:0] addr0, wdata0, rdata0;
   logic        ready0, ack0, err0, busy0;

   int total = 0;
   int bad   = 0;

   logic [31:0] baddr [3];
   logic [31:0] bexp  [3];

   always #5 clk = ~clk;

   data_mem_responder #(.DEPTH(256), .WAIT_CYCLES(2)) dut (
      .clk   (clk),
      .reset (reset),
      .req   (req),
      .we    (we),
      .addr  (addr),
      .wdata (wdata),
      .ready (ready),
      .ack   (ack),
      .rdata (rdata),
      .err   (err),
      .busy  (busy)
   );

   data_mem_responder #(.DEPTH(256), .WAIT_CYCLES(0)) dut0 (
      .clk   (clk),
      .reset (reset),
      .req   (req0),
      .we    (we0),
      .addr  (addr0),
      .wdata (wdata0),
      .ready (ready0),
      .ack   (ack0),
      .rdata (rdata0),
      .err   (err0),
      .busy  (busy0)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One request on the WAIT_CYCLES=2 instance; inputs are scrambled while busy.
   task automatic xact(input string tag, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic exp_err, input logic [31:0] exp_rd);
      int lat;
      check({tag, " ready"}, 32'(ready), 32'd1);
      req = 1'b1; we = w; addr = a; wdata = d;
      step();
      req = 1'b0; we = ~w; addr = 32'h0000_003C; wdata = 32'hFFFF_FFFF;
      lat = 0;
      while (ack !== 1'b1 && lat < 20) begin
         step();
         lat++;
      end
      check({tag, " latency"}, 32'(lat), 32'd2);
      check({tag, " err"}, 32'(err), 32'(exp_err));
      check({tag, " rdata"}, rdata, exp_rd);
      check({tag, " ready in resp"}, 32'(ready), 32'd0);
      step();
      check({tag, " ack falls"}, 32'(ack), 32'd0);
      check({tag, " ready back"}, 32'(ready), 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      int last;
      logic rdy;

      baddr = '{32'h10, 32'h14, 32'h18};
      bexp  = '{32'h1234_5678, 32'hA5A5_A5A5, 32'h0F0F_0F0F};
      reset = 1'b1;
      req = 1'b0; we = 1'b0; addr = 32'd0; wdata = 32'd0;
      req0 = 1'b0; we0 = 1'b0; addr0 = 32'd0; wdata0 = 32'd0;
      step();
      check("reset ready", 32'(ready), 32'd1);
      check("reset ack", 32'(ack), 32'd0);
      check("reset err", 32'(err), 32'd0);
      check("reset rdata", rdata, 32'd0);
      check("reset busy", 32'(busy), 32'd0);
      reset = 1'b0;
      step();

      // Basic store/load plus byte ordering
      xact("st10", 1'b1, 32'h10, 32'h1234_5678, 1'b0, 32'd0);
      check("byte mem10", 32'(dut.mem[16]), 32'h12);
      check("byte mem13", 32'(dut.mem[19]), 32'h78);
      xact("ld10", 1'b0, 32'h10, 32'd0, 1'b0, 32'h1234_5678);

      // Error cases keep rdata and memory intact
      xact("ld11 misaligned", 1'b0, 32'h11, 32'd0, 1'b1, 32'h1234_5678);
      xact("st00", 1'b1, 32'h00, 32'h0BAD_F00D, 1'b0, 32'h1234_5678);
      xact("stFC", 1'b1, 32'hFC, 32'h0102_0304, 1'b0, 32'h1234_5678);
      xact("st100 range", 1'b1, 32'h100, 32'h5555_5555, 1'b1, 32'h1234_5678);
      xact("st top range", 1'b1, 32'hFFFF_FFFC, 32'h6666_6666, 1'b1, 32'h1234_5678);
      xact("ldFC kept", 1'b0, 32'hFC, 32'd0, 1'b0, 32'h0102_0304);
      xact("ld00 kept", 1'b0, 32'h00, 32'd0, 1'b0, 32'h0BAD_F00D);

      // Last word boundary
      xact("stFC beef", 1'b1, 32'hFC, 32'hDEAD_BEEF, 1'b0, 32'h0BAD_F00D);
      xact("ldFC beef", 1'b0, 32'hFC, 32'd0, 1'b0, 32'hDEAD_BEEF);

      // Back-to-back loads with req held high
      xact("st14", 1'b1, 32'h14, 32'hA5A5_A5A5, 1'b0, 32'hDEAD_BEEF);
      xact("st18", 1'b1, 32'h18, 32'h0F0F_0F0F, 1'b0, 32'hDEAD_BEEF);
      req = 1'b1; we = 1'b0; addr = baddr[0];
      k = 0;
      last = 0;
      for (int c = 1; c <= 16; c++) begin
         rdy = ready;
         step();
         if (rdy && req) begin
            addr = 32'h0000_003C;
            check("burst busy after accept", 32'(busy), 32'd1);
         end
         if (ack) begin
            check("burst ready in resp", 32'(ready), 32'd0);
            if (k < 3) begin
               check("burst rdata", rdata, bexp[k]);
               if (k > 0) check("burst ack spacing", 32'(c - last), 32'd4);
               last = c;
            end
            k++;
            if (k < 3) addr = baddr[k];
            else req = 1'b0;
         end
      end
      check("burst ack count", 32'(k), 32'd3);

      // Reset while a store is waiting to commit
      xact("st20 old", 1'b1, 32'h20, 32'h1357_2468, 1'b0, 32'h0F0F_0F0F);
      req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'hAAAA_5555;
      step();
      req = 1'b0;
      check("abort busy", 32'(busy), 32'd1);
      step();
      check("abort no ack yet", 32'(ack), 32'd0);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("abort ack", 32'(ack), 32'd0);
      check("abort ready", 32'(ready), 32'd1);
      check("abort rdata cleared", rdata, 32'd0);
      for (int c = 0; c < 3; c++) begin
         step();
         check("abort stays idle", 32'(ack), 32'd0);
      end
      xact("ld20 old", 1'b0, 32'h20, 32'd0, 1'b0, 32'h1357_2468);

      // Zero-wait instance
      req0 = 1'b1; we0 = 1'b1; addr0 = 32'h40; wdata0 = 32'hFEED_C0DE;
      step();
      req0 = 1'b0; wdata0 = 32'd0;
      check("w0 st ack", 32'(ack0), 32'd1);
      check("w0 st ready", 32'(ready0), 32'd0);
      check("w0 st err", 32'(err0), 32'd0);
      step();
      check("w0 st ack falls", 32'(ack0), 32'd0);
      check("w0 st ready back", 32'(ready0), 32'd1);
      req0 = 1'b1; we0 = 1'b0; addr0 = 32'h40;
      step();
      req0 = 1'b0; addr0 = 32'h0;
      check("w0 ld ack", 32'(ack0), 32'd1);
      check("w0 ld rdata", rdata0, 32'hFEED_C0DE);
      step();
      check("w0 ld ready back", 32'(ready0), 32'd1);
      check("w0 ld ack falls", 32'(ack0), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
